// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_if
// Purpose  : Byte-stream handshake between the UART buffer controller
//            (master) and the UART transmit serializer (slave), plus the
//            serializer's line and frame status outputs.
// Signals  : send       master->slave  byte strobe
//            data[7:0]  master->slave  byte to send, valid with send
//            ready      slave->master  1 = serializer idle, send accepted
//            tx         slave->master  serial line, idle high, LSB first
//            frame_done slave->master  pulse on last cycle of final stop bit
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_serializer_if;
  logic       send;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       frame_done;

  modport master (output send, data, input ready, tx, frame_done);
  modport slave  (input send, data, output ready, tx, frame_done);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : 8N1 / 8N2 UART transmitter. Accepts one byte per send strobe
//            while ready=1 and shifts it out start bit, 8 data bits LSB
//            first, then STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
// Ports    : clk   system clock, rising edge
//            rst   synchronous reset, active-high
//            bus   uart_tx_serializer_if.slave (send, data, ready, tx,
//                  frame_done); all outputs are registered
// Params   : CLKS_PER_BIT  clocks per bit, >= 2
//            STOP_BITS     1 or 2
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int STOP_BITS    = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  uart_tx_serializer_if.slave bus
);

  localparam int              c_cw           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cw-1:0] c_baud_last    = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_baud_prelast = c_cw'(CLKS_PER_BIT - 2);
  localparam logic [2:0]      c_stop_last    = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state, w_state_n;
  logic [c_cw-1:0] r_baud,  w_baud_n;
  logic [2:0]      r_bit,   w_bit_n;    // data bit index, reused as stop-bit index
  logic [7:0]      r_shift, w_shift_n;
  logic            r_tx,    w_tx_n;
  logic            r_ready, w_ready_n;
  logic            r_done,  w_done_n;
  logic            w_wrap;

  assign w_wrap = (r_baud == c_baud_last);

  // Outputs are registered: every w_*_n below is the value the line will
  // carry during the cycle after the coming edge.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_ready_n = r_ready;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.send) begin
          w_state_n = S_START;
          w_shift_n = bus.data;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_tx_n    = 1'b0;
          w_ready_n = 1'b0;
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state_n = S_DATA;
          w_baud_n  = '0;
          w_tx_n    = r_shift[0];
        end else begin
          w_baud_n  = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
            w_bit_n   = '0;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n   = r_bit + 1'b1;
            w_shift_n = {1'b0, r_shift[7:1]};
            // next bit on the line is the one that lands in shift[0]
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          w_baud_n = '0;
          if (r_bit == c_stop_last) begin
            w_state_n = S_IDLE;
            w_bit_n   = '0;
            w_ready_n = 1'b1;
          end else begin
            w_bit_n   = r_bit + 1'b1;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
          // registered pulse: raise one cycle early so it shows on the
          // final cycle of the last stop bit
          w_done_n = (r_baud == c_baud_prelast) && (r_bit == c_stop_last);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
        w_ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_ready <= w_ready_n;
      r_done  <= w_done_n;
    end
  end

  assign bus.tx         = r_tx;
  assign bus.ready      = r_ready;
  assign bus.frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Purpose  : Self-checking bench for uart_tx_serializer. Three instances:
//            A (4 clk/bit, 1 stop), B (4 clk/bit, 2 stop), C (2 clk/bit,
//            1 stop). A frame-level model predicts tx/ready/frame_done every
//            cycle; directed sequences add literal expectations and a line
//            receiver decodes instance A.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serializer_if ifa ();
  uart_tx_serializer_if ifb ();
  uart_tx_serializer_if ifc ();

  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_tx_serializer #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] w_send, w_tx, w_rdy, w_done;
  logic [7:0] w_data [3];
  assign w_send   = {ifc.send, ifb.send, ifa.send};
  assign w_tx     = {ifc.tx, ifb.tx, ifa.tx};
  assign w_rdy    = {ifc.ready, ifb.ready, ifa.ready};
  assign w_done   = {ifc.frame_done, ifb.frame_done, ifa.frame_done};
  assign w_data[0] = ifa.data;
  assign w_data[1] = ifb.data;
  assign w_data[2] = ifc.data;

  function automatic int cpb_of(input int i);
    return (i == 2) ? 2 : 4;
  endfunction
  function automatic int sb_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int flen(input int i);
    return (9 + sb_of(i)) * cpb_of(i);
  endfunction

  // Line level k cycles after the accept edge: start, 8 data LSB first, stop.
  function automatic logic exp_tx(input logic busy, input int k, input logic [7:0] b, input int cpb);
    int idx;
    if (!busy) return 1'b1;
    idx = k / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // ---------------- frame-level model ----------------
  logic [2:0] m_busy = 3'b000;
  int         m_k    [3];
  logic [7:0] m_byte [3];
  logic       armed  = 1'b0;

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
      end else if (m_busy[i]) begin
        m_k[i]    <= m_k[i] + 1;
        m_busy[i] <= ((m_k[i] + 1) != flen(i));
      end else if (w_send[i]) begin
        m_busy[i] <= 1'b1;
        m_k[i]    <= 0;
        m_byte[i] <= w_data[i];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int i = 0; i < 3; i++) begin
          logic et, er, ed;
          et = exp_tx(m_busy[i], m_k[i], m_byte[i], cpb_of(i));
          er = !m_busy[i];
          ed = m_busy[i] && (m_k[i] == flen(i) - 1);
          n_vec++;
          if (w_tx[i] !== et || w_rdy[i] !== er || w_done[i] !== ed) begin
            n_err++;
            $display("FAIL model dut%0d t=%0t: tx/ready/frame_done got %b%b%b expected %b%b%b",
                     i, $time, w_tx[i], w_rdy[i], w_done[i], et, er, ed);
          end
        end
      end
    end
  end

  // ---------------- receiver on instance A (4 clk/bit) ----------------
  int         rx_cnt = 0;
  logic [7:0] rx_sh  = 8'h00;
  logic [7:0] rx_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_cnt = 0;
      end else if (rx_cnt == 0) begin
        if (ifa.tx === 1'b0) rx_cnt = 1;
      end else begin
        rx_cnt++;
        // sample centre of each data bit; count 1 is the first start cycle
        if (rx_cnt >= 7 && rx_cnt <= 35 && (rx_cnt % 4) == 3)
          rx_sh = {ifa.tx, rx_sh[7:1]};
        if (rx_cnt == 39) begin
          if (ifa.tx === 1'b1) rx_q.push_back(rx_sh);
          rx_cnt = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input int d, input logic [7:0] v);
    case (d)
      0: begin ifa.send = 1'b1; ifa.data = v; end
      1: begin ifb.send = 1'b1; ifb.data = v; end
      default: begin ifc.send = 1'b1; ifc.data = v; end
    endcase
    @(negedge clk);
    case (d)
      0: ifa.send = 1'b0;
      1: ifb.send = 1'b0;
      default: ifc.send = 1'b0;
    endcase
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp);
    chk({name, "_rx_avail"}, (rx_q.size() > 0) ? 1 : 0, 1);
    if (rx_q.size() > 0) chk({name, "_rx_byte"}, rx_q.pop_front(), exp);
  endtask

  initial begin
    logic [9:0] lit;
    logic [7:0] nxt [2];
    int rl, dp, dj, cnt, lo, hi;

    ifa.send = 1'b0; ifa.data = 8'h00;
    ifb.send = 1'b0; ifb.data = 8'h00;
    ifc.send = 1'b0; ifc.data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", ifa.tx, 1);
    chk("reset_ready", ifa.ready, 1);
    chk("reset_done", ifa.frame_done, 0);

    // T1: 0x0D -> 0,1,0,1,1,0,0,0,0,1
    lit = 10'b1000011010;
    start(0, 8'h0D);
    rl = 0; dp = 0; dj = -1;
    for (int j = 0; j < 40; j++) begin
      if (j % 4 == 2) chk($sformatf("t1_bit%0d", j / 4), w_tx[0], lit[j / 4]);
      if (!w_rdy[0]) rl++;
      if (w_done[0]) begin dp++; dj = j + 1; end
      @(negedge clk);
    end
    chk("t1_ready_low", rl, 40);
    chk("t1_done_pulses", dp, 1);
    chk("t1_done_cycle", dj, 40);
    chk("t1_ready_back", w_rdy[0], 1);
    chk_rx("t1", 8'h0D);

    // T2: send 0xFF mid-frame of 0x0A is ignored
    start(0, 8'h0A);
    rl = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 10) begin ifa.send = 1'b1; ifa.data = 8'hFF; end
      if (j == 11) ifa.send = 1'b0;
      if (!w_rdy[0]) rl++;
      @(negedge clk);
    end
    chk("t2_ready_low", rl, 40);
    rl = 0; dp = 0;
    for (int j = 0; j < 50; j++) begin
      if (!w_rdy[0]) rl++;
      if (w_done[0]) dp++;
      @(negedge clk);
    end
    chk("t2_no_second_frame", rl, 0);
    chk("t2_no_extra_done", dp, 0);
    chk_rx("t2", 8'h0A);
    chk("t2_rx_single", rx_q.size(), 0);

    // T3: reset during data bit 3 of 0x55
    start(0, 8'h55);
    dp = 0;
    for (int j = 0; j < 17; j++) begin
      if (w_done[0]) dp++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t3_tx_after_rst", w_tx[0], 1);
    chk("t3_ready_after_rst", w_rdy[0], 1);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 30; j++) begin
      if (w_done[0]) dp++;
      @(negedge clk);
    end
    chk("t3_no_done", dp, 0);
    chk("t3_no_partial_byte", rx_q.size(), 0);
    start(0, 8'h20);
    repeat (40) @(negedge clk);
    chk("t3_ready_back", w_rdy[0], 1);
    chk_rx("t3", 8'h20);

    // T4: send held high, new byte on each ready rise
    nxt[0] = 8'h0A;
    nxt[1] = 8'h20;
    ifa.send = 1'b1;
    ifa.data = 8'h0D;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      cnt = 0;
      while (w_rdy[0] !== 1'b1 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      chk($sformatf("t4_len%0d", f), cnt, 40);
      if (f < 2) begin
        ifa.data = nxt[f];
        @(negedge clk);
        chk($sformatf("t4_gap%0d", f), w_rdy[0], 0);
      end
    end
    ifa.send = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_rx_count", rx_q.size(), 3);
    chk_rx("t4a", 8'h0D);
    chk_rx("t4b", 8'h0A);
    chk_rx("t4c", 8'h20);

    // T5: two stop bits, 0x00
    start(1, 8'h00);
    lo = 0; hi = 0; rl = 0;
    for (int j = 0; j < 44; j++) begin
      if (w_tx[1] === 1'b0) lo++; else hi++;
      if (j == 35) chk("t5_last_low", w_tx[1], 0);
      if (j == 36) chk("t5_first_stop", w_tx[1], 1);
      if (!w_rdy[1]) rl++;
      @(negedge clk);
    end
    chk("t5_low_cycles", lo, 36);
    chk("t5_high_cycles", hi, 8);
    chk("t5_ready_low", rl, 44);
    chk("t5_ready_back", w_rdy[1], 1);

    // T6: 2 clk/bit, 0xA5
    lit = 10'b1101001010;
    start(2, 8'hA5);
    rl = 0;
    for (int j = 0; j < 20; j++) begin
      if (j % 2 == 1) chk($sformatf("t6_bit%0d", j / 2), w_tx[2], lit[j / 2]);
      if (!w_rdy[2]) rl++;
      @(negedge clk);
    end
    chk("t6_ready_low", rl, 20);
    chk("t6_ready_back", w_rdy[2], 1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
